seven_segment_mux: RTL and testbench

Multiplexed multi-digit seven-segment driver for the sequencer front panel. It holds one note code per digit, time-multiplexes the digits at a parametrised refresh rate, and can blink one selected digit to mark the current step. It sits between the step sequencer, which writes the note codes, and the board's common-anode or common-cathode display pins.

---
 rtl/seven_segment_mux_if.sv | 26 ++
 rtl/seven_segment_mux.sv | 143 ++++++++++++++
 tb/tb_seven_segment_mux.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_mux_if.sv
// Front-panel display bus: note writes and blink control from the step sequencer,
// multiplexed segment/digit drive toward the display pins.
interface seven_segment_mux_if #(
    parameter int NUM_DIGITS = 4
) ();
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                  wr_en;
    logic [IW-1:0]         wr_idx;
    logic [7:0]            wr_note;
    logic                  blink_en;
    logic [IW-1:0]         blink_idx;
    logic [6:0]            seg_data;
    logic                  decimal;
    logic [NUM_DIGITS-1:0] digit_en;

    modport master (
        output wr_en, wr_idx, wr_note, blink_en, blink_idx,
        input  seg_data, decimal, digit_en
    );

    modport slave (
        input  wr_en, wr_idx, wr_note, blink_en, blink_idx,
        output seg_data, decimal, digit_en
    );
endinterface

// File: rtl/seven_segment_mux.sv
// Multiplexed seven-segment driver: per-digit note store, digit scan with an
// anti-ghosting blank cycle per slot, optional blink of one digit, registered pins.
module seven_segment_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int BLINK_DIV   = 12000000,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    seven_segment_mux_if.slave bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] SCAN_LAST  = SW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [IW-1:0] DIGIT_LAST = IW'(NUM_DIGITS - 1);

    localparam logic [6:0]            SEG_IDLE = {7{ACTIVE_LOW}};
    localparam logic                  DP_IDLE  = ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] EN_IDLE  = {NUM_DIGITS{ACTIVE_LOW}};

    // Note code to {g,f,e,d,c,b,a, dp}.
    function automatic logic [7:0] decode_note(input logic [7:0] note);
        logic [7:0] sd;
        case (note)
            8'd0:    sd = {7'b0000000, 1'b0};
            8'd1:    sd = {7'b0111001, 1'b0};
            8'd2:    sd = {7'b1011110, 1'b0};
            8'd3:    sd = {7'b1111001, 1'b0};
            8'd4:    sd = {7'b1110001, 1'b0};
            8'd5:    sd = {7'b0111101, 1'b0};
            8'd6:    sd = {7'b1110111, 1'b0};
            8'd7:    sd = {7'b1111100, 1'b0};
            8'd8:    sd = {7'b0111001, 1'b1};
            default: sd = {7'b1000000, 1'b0};
        endcase
        return sd;
    endfunction

    function automatic logic [6:0] pin_seg(input logic [6:0] v);
        return ACTIVE_LOW ? ~v : v;
    endfunction

    function automatic logic pin_dp(input logic v);
        return ACTIVE_LOW ? ~v : v;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] pin_en(input logic [NUM_DIGITS-1:0] v);
        return ACTIVE_LOW ? ~v : v;
    endfunction

    logic [7:0]            store_q [NUM_DIGITS];
    logic [7:0]            store_d [NUM_DIGITS];
    logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]         digit_idx_q, digit_idx_d;
    logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;

    logic                  scan_wrap;
    logic                  blink_wrap;
    logic [7:0]            cur_note;
    logic [7:0]            seg_dp_f;
    logic [NUM_DIGITS-1:0] en_f;

    // Store, scan and blink timebase next state.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            store_d[i] = store_q[i];
            if (bus.wr_en && (bus.wr_idx == IW'(i))) begin
                store_d[i] = bus.wr_note;
            end
        end

        scan_wrap   = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SW'(1);
        digit_idx_d = digit_idx_q;
        if (scan_wrap) begin
            digit_idx_d = (digit_idx_q == DIGIT_LAST) ? '0 : digit_idx_q + IW'(1);
        end

        blink_wrap    = (blink_cnt_q == BLINK_LAST);
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q ^ blink_wrap;
    end

    // Display function of the current state, captured into the pin registers.
    always_comb begin
        cur_note = 8'd0;
        en_f     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx_q == IW'(i)) begin
                cur_note = store_q[i];
                en_f[i]  = (scan_cnt_q != '0);
            end
        end

        seg_dp_f = decode_note(cur_note);
        if (bus.blink_en && (bus.blink_idx == digit_idx_q) && blink_phase_q) begin
            seg_dp_f = 8'd0;
        end

        seg_d = pin_seg(seg_dp_f[7:1]);
        dp_d  = pin_dp(seg_dp_f[0]);
        en_d  = pin_en(en_f);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                store_q[i] <= 8'd0;
            end
            scan_cnt_q    <= '0;
            digit_idx_q   <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_IDLE;
            dp_q          <= DP_IDLE;
            en_q          <= EN_IDLE;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                store_q[i] <= store_d[i];
            end
            scan_cnt_q    <= scan_cnt_d;
            digit_idx_q   <= digit_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            en_q          <= en_d;
        end
    end

    assign bus.seg_data = seg_q;
    assign bus.decimal  = dp_q;
    assign bus.digit_en = en_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Bench for seven_segment_mux: three instances (4 digits, 3 digits, 4 digits active-low)
// driven in lockstep; table-driven first frames, then scoreboarded scenario sequences.
module tb_seven_segment_mux;
    localparam int RD = 4;
    localparam int BD = 16;

    typedef struct packed {
        logic [3:0] en;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    typedef struct packed {
        logic       we;
        logic [1:0] idx;
        logic [7:0] note;
        out_t       exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_segment_mux_if #(.NUM_DIGITS(4)) if0 ();
    seven_segment_mux_if #(.NUM_DIGITS(3)) if1 ();
    seven_segment_mux_if #(.NUM_DIGITS(4)) if2 ();

    seven_segment_mux #(.NUM_DIGITS(4), .REFRESH_DIV(RD), .BLINK_DIV(BD), .ACTIVE_LOW(1'b0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    seven_segment_mux #(.NUM_DIGITS(3), .REFRESH_DIV(RD), .BLINK_DIV(BD), .ACTIVE_LOW(1'b0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    seven_segment_mux #(.NUM_DIGITS(4), .REFRESH_DIV(RD), .BLINK_DIV(BD), .ACTIVE_LOW(1'b1))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    out_t       q0[$], q1[$], q2[$];
    logic [7:0] sh0 [4];
    logic [7:0] sh1 [4];
    logic [7:0] sh2 [4];
    out_t       a0, a1, a2;
    vec_t       tab [32];
    int         c;
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic logic [7:0] decode(input logic [7:0] n);
        case (n)
            8'd0:    return {7'b0000000, 1'b0};
            8'd1:    return {7'b0111001, 1'b0};
            8'd2:    return {7'b1011110, 1'b0};
            8'd3:    return {7'b1111001, 1'b0};
            8'd4:    return {7'b1110001, 1'b0};
            8'd5:    return {7'b0111101, 1'b0};
            8'd6:    return {7'b1110111, 1'b0};
            8'd7:    return {7'b1111100, 1'b0};
            8'd8:    return {7'b0111001, 1'b1};
            default: return {7'b1000000, 1'b0};
        endcase
    endfunction

    // Expected pins at the edge that consumes state count cc (edges since reset release).
    function automatic out_t model(input int nd, input bit al, input logic [7:0] st [4],
                                   input logic ben, input int bidx, input int cc);
        out_t       o;
        int         d;
        logic [7:0] sd;
        d     = (cc / RD) % nd;
        o.en  = ((cc % RD) == 0) ? 4'b0000 : 4'(1 << d);
        sd    = decode(st[d]);
        o.seg = sd[7:1];
        o.dp  = sd[0];
        if (ben && (d == bidx) && (((cc / BD) % 2) == 1)) begin
            o.seg = 7'b0000000;
            o.dp  = 1'b0;
        end
        if (al) begin
            o.en  = ~o.en;
            o.seg = ~o.seg;
            o.dp  = ~o.dp;
        end
        if (nd < 4) o.en[3] = 1'b0;
        return o;
    endfunction

    function automatic out_t idle(input bit al);
        return al ? 12'hFFF : 12'h000;
    endfunction

    function automatic vec_t mk(input logic we, input logic [1:0] idx, input logic [7:0] note,
                                input logic [3:0] en, input logic [6:0] seg, input logic dp);
        vec_t v;
        v.we = we; v.idx = idx; v.note = note;
        v.exp.en = en; v.exp.seg = seg; v.exp.dp = dp;
        return v;
    endfunction

    task automatic chk(input string name, input out_t act, input out_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (c=%0d): got en=%b seg=%b dp=%b, expected en=%b seg=%b dp=%b",
                     name, c, act.en, act.seg, act.dp, exp.en, exp.seg, exp.dp);
        end
    endtask

    task automatic sample();
        a0 = {if0.digit_en, if0.seg_data, if0.decimal};
        a1 = {1'b0, if1.digit_en, if1.seg_data, if1.decimal};
        a2 = {if2.digit_en, if2.seg_data, if2.decimal};
    endtask

    // One clock: push expectations for this edge, clock, update shadows, pop and compare.
    task automatic cycle(input bit use_tab, input out_t tab_exp, input string tag);
        if (!rst_n) begin
            q0.push_back(idle(1'b0));
            q1.push_back(idle(1'b0));
            q2.push_back(idle(1'b1));
        end else begin
            q0.push_back(use_tab ? tab_exp : model(4, 1'b0, sh0, if0.blink_en, int'(if0.blink_idx), c));
            q1.push_back(model(3, 1'b0, sh1, if1.blink_en, int'(if1.blink_idx), c));
            q2.push_back(model(4, 1'b1, sh2, if2.blink_en, int'(if2.blink_idx), c));
        end
        @(posedge clk);
        if (rst_n) begin
            if (if0.wr_en) sh0[if0.wr_idx] = if0.wr_note;
            if (if1.wr_en && (if1.wr_idx < 2'd3)) sh1[if1.wr_idx] = if1.wr_note;
            if (if2.wr_en) sh2[if2.wr_idx] = if2.wr_note;
            c++;
        end
        #1;
        sample();
        chk({tag, "_d0"}, a0, q0.pop_front());
        chk({tag, "_d1"}, a1, q1.pop_front());
        chk({tag, "_d2"}, a2, q2.pop_front());
    endtask

    task automatic drive_wr(input logic we, input logic [1:0] idx, input logic [7:0] note);
        if0.wr_en = we; if0.wr_idx = idx; if0.wr_note = note;
        if1.wr_en = we; if1.wr_idx = idx; if1.wr_note = note;
        if2.wr_en = we; if2.wr_idx = idx; if2.wr_note = note;
    endtask

    task automatic drive_blink(input logic en, input logic [1:0] idx);
        if0.blink_en = en; if0.blink_idx = idx;
        if1.blink_en = en; if1.blink_idx = idx;
        if2.blink_en = en; if2.blink_idx = idx;
    endtask

    task automatic clear_shadows();
        for (int i = 0; i < 4; i++) begin
            sh0[i] = 8'd0; sh1[i] = 8'd0; sh2[i] = 8'd0;
        end
    endtask

    initial begin
        int guard;
        // Frame 0 (writes in the first four cycles), then an idle frame 1.
        tab[0]  = mk(1'b1, 2'd0, 8'd1,   4'b0000, 7'b0000000, 1'b0);
        tab[1]  = mk(1'b1, 2'd1, 8'd8,   4'b0001, 7'b0111001, 1'b0);
        tab[2]  = mk(1'b1, 2'd2, 8'd0,   4'b0001, 7'b0111001, 1'b0);
        tab[3]  = mk(1'b1, 2'd3, 8'd200, 4'b0001, 7'b0111001, 1'b0);
        tab[4]  = mk(1'b0, 2'd0, 8'd0,   4'b0000, 7'b0111001, 1'b1);
        tab[5]  = mk(1'b0, 2'd0, 8'd0,   4'b0010, 7'b0111001, 1'b1);
        tab[6]  = mk(1'b0, 2'd0, 8'd0,   4'b0010, 7'b0111001, 1'b1);
        tab[7]  = mk(1'b0, 2'd0, 8'd0,   4'b0010, 7'b0111001, 1'b1);
        tab[8]  = mk(1'b0, 2'd0, 8'd0,   4'b0000, 7'b0000000, 1'b0);
        tab[9]  = mk(1'b0, 2'd0, 8'd0,   4'b0100, 7'b0000000, 1'b0);
        tab[10] = mk(1'b0, 2'd0, 8'd0,   4'b0100, 7'b0000000, 1'b0);
        tab[11] = mk(1'b0, 2'd0, 8'd0,   4'b0100, 7'b0000000, 1'b0);
        tab[12] = mk(1'b0, 2'd0, 8'd0,   4'b0000, 7'b1000000, 1'b0);
        tab[13] = mk(1'b0, 2'd0, 8'd0,   4'b1000, 7'b1000000, 1'b0);
        tab[14] = mk(1'b0, 2'd0, 8'd0,   4'b1000, 7'b1000000, 1'b0);
        tab[15] = mk(1'b0, 2'd0, 8'd0,   4'b1000, 7'b1000000, 1'b0);
        for (int i = 16; i < 32; i++) begin
            tab[i]    = tab[i-16];
            tab[i].we = 1'b0;
        end
        tab[16].exp.seg = 7'b0111001;

        drive_wr(1'b0, 2'd0, 8'd0);
        drive_blink(1'b0, 2'd0);
        clear_shadows();
        c = 0;

        // Held in reset: every pin inactive.
        repeat (3) cycle(1'b0, '0, "reset");

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            drive_wr(tab[i].we, tab[i].idx, tab[i].note);
            cycle(1'b1, tab[i].exp, "frame");
        end
        drive_wr(1'b0, 2'd0, 8'd0);

        // Blink digit 1 across four blink half-periods.
        drive_blink(1'b1, 2'd1);
        for (int i = 0; i < 64; i++) begin
            int cc;
            cc = c;
            cycle(1'b0, '0, "blink");
            if (cc == 37) chk("blink_visible", a0, {4'b0010, 7'b0111001, 1'b1});
            if (cc == 53) chk("blink_hidden", a0, {4'b0010, 7'b0000000, 1'b0});
            if (cc == 52) chk("blink_hidden_blank", a0, {4'b0000, 7'b0000000, 1'b0});
        end
        drive_blink(1'b0, 2'd0);

        // Out-of-range write to the 3-digit instance.
        if1.wr_en = 1'b1; if1.wr_idx = 2'd3; if1.wr_note = 8'd5;
        cycle(1'b0, '0, "oor_wr");
        if1.wr_en = 1'b0;
        for (int i = 0; i < 24; i++) begin
            int cc;
            cc = c;
            cycle(1'b0, '0, "oor");
            if ((cc % 12) == 1) chk("oor_wrap_d0", a1, {4'b0001, 7'b0111001, 1'b0});
            if ((cc % 12) == 5) chk("oor_d1", a1, {4'b0010, 7'b0111001, 1'b1});
            if ((cc % 12) == 9) chk("oor_d2", a1, {4'b0100, 7'b0000000, 1'b0});
        end

        // Write latency on the displayed digit.
        guard = 0;
        while (((c % 16) != 1) && (guard < 32)) begin
            cycle(1'b0, '0, "wlat_align");
            guard++;
        end
        if0.wr_en = 1'b1; if0.wr_idx = 2'd0; if0.wr_note = 8'd4;
        if2.wr_en = 1'b1; if2.wr_idx = 2'd0; if2.wr_note = 8'd3;
        cycle(1'b0, '0, "wlat_edge");
        chk("wlat_sample_edge", a0, {4'b0001, 7'b0111001, 1'b0});
        if0.wr_en = 1'b0;
        if2.wr_en = 1'b0;
        cycle(1'b0, '0, "wlat_next");
        chk("wlat_new_value", a0, {4'b0001, 7'b1110001, 1'b0});
        chk("active_low_e4", a2, {4'b1110, 7'b0000110, 1'b1});
        repeat (4) cycle(1'b0, '0, "wlat_tail");

        // Asynchronous reset in the middle of digit 2's slot.
        guard = 0;
        while (((c % 16) != 9) && (guard < 32)) begin
            cycle(1'b0, '0, "mid_align");
            guard++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        sample();
        chk("async_rst_d0", a0, idle(1'b0));
        chk("async_rst_d1", a1, idle(1'b0));
        chk("async_rst_d2", a2, idle(1'b1));
        c = 0;
        clear_shadows();
        repeat (2) cycle(1'b0, '0, "mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, '0, "restart");
        chk("restart_blank", a0, {4'b0000, 7'b0000000, 1'b0});
        cycle(1'b0, '0, "restart");
        chk("restart_rest_d0", a0, {4'b0001, 7'b0000000, 1'b0});
        repeat (14) cycle(1'b0, '0, "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
